// File: rtl/appmult_pkg.sv
// Shared types and helpers for the sequential 12x12 approximate multiplier.
// APPMULT_SKIP_ZERO_EN enables skipping of zero half-product steps.
package appmult_pkg;

   localparam int HALF_W = 6;
   localparam int OP_W   = 12;
   localparam int PROD_W = 24;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
   typedef enum logic [1:0] {LL, LH, HL, HH} step_t;

   function automatic logic [3:0] step_shift(step_t s);
      logic [3:0] sh;
      sh = 4'd0;
      unique case (s)
         LL:      sh = 4'd0;
         LH, HL:  sh = 4'd6;
         HH:      sh = 4'd12;
      endcase
      return sh;
   endfunction

   // Bit n set when step n has both operand halves nonzero.
   function automatic logic [3:0] step_mask(
      logic [OP_W-1:0] a,
      logic [OP_W-1:0] b
   );
      logic al, ah, bl, bh;
      al = |a[5:0];
      ah = |a[11:6];
      bl = |b[5:0];
      bh = |b[11:6];
      return {ah & bh, ah & bl, al & bh, al & bl};
   endfunction

   function automatic step_t first_step(logic [3:0] m);
      step_t s;
      if (m[0])      s = LL;
      else if (m[1]) s = LH;
      else if (m[2]) s = HL;
      else           s = HH;
      return s;
   endfunction

endpackage

// File: rtl/appmult_seq_12x12_mult_6_6.sv
// Existing 6x6 approximate core: partial-product columns of
// weight 2^0..2^3 are dropped, no error compensation.
module Mult_6_6 (
   input  logic [5:0]  a,
   input  logic [5:0]  b,
   output logic [11:0] p
);

   always_comb begin
      p = '0;
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 6; j++) begin
            if (i + j >= 4)
               p = p + (12'(a[i] & b[j]) << (i + j));
         end
      end
   end

endmodule

// File: rtl/appmult_seq_12x12.sv
// Sequential 12x12 approximate multiplier over one shared Mult_6_6.
// APPMULT_SKIP_ZERO_EN: skip steps whose operand half is zero.
module appmult_seq_12x12 #(
   parameter int TAG_W = 4,
   parameter int ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [11:0]      in_a,
   input  logic [11:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_prod,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   import appmult_pkg::*;

   if (ACC_W != 2 * OP_W) begin : g_bad_acc_w
      $fatal(1, "appmult_seq_12x12: ACC_W must be 24");
   end

   state_t           state;
   step_t            step;
   logic [OP_W-1:0]  a_q;
   logic [OP_W-1:0]  b_q;
   logic [TAG_W-1:0] tag_q;
   logic [ACC_W-1:0] acc;
   logic [3:0]       mask_q;

   logic [5:0]       core_a;
   logic [5:0]       core_b;
   logic [11:0]      core_p;
   logic [ACC_W-1:0] acc_nxt;
   logic [3:0]       in_mask;
   logic [3:0]       rem;

`ifdef APPMULT_SKIP_ZERO_EN
   assign in_mask = step_mask(in_a, in_b);
`else
   assign in_mask = 4'hF;
`endif

   always_comb begin
      core_a = a_q[5:0];
      core_b = b_q[5:0];
      unique case (step)
         LL: begin core_a = a_q[5:0];  core_b = b_q[5:0];  end
         LH: begin core_a = a_q[5:0];  core_b = b_q[11:6]; end
         HL: begin core_a = a_q[11:6]; core_b = b_q[5:0];  end
         HH: begin core_a = a_q[11:6]; core_b = b_q[11:6]; end
      endcase
   end

   Mult_6_6 u_core (
      .a (core_a),
      .b (core_b),
      .p (core_p)
   );

   assign acc_nxt = acc + (ACC_W'(core_p) << step_shift(step));

   // Steps still pending after the current one.
   assign rem = mask_q & ~((4'd2 << step) - 4'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         step      <= LL;
         a_q       <= '0;
         b_q       <= '0;
         tag_q     <= '0;
         acc       <= '0;
         mask_q    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_prod  <= '0;
         out_tag   <= '0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_q      <= in_a;
                  b_q      <= in_b;
                  tag_q    <= in_tag;
                  acc      <= '0;
                  mask_q   <= in_mask;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (in_mask == 4'd0) begin
                     state     <= DONE;
                     step      <= LL;
                     out_valid <= 1'b1;
                     out_prod  <= '0;
                     out_tag   <= in_tag;
                  end else begin
                     state <= MUL;
                     step  <= first_step(in_mask);
                  end
               end
            end
            MUL: begin
               acc <= acc_nxt;
               if (rem == 4'd0) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  out_prod  <= acc_nxt;
                  out_tag   <= tag_q;
               end else begin
                  step <= first_step(rem);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_appmult_seq_12x12.sv
// Scoreboard bench for appmult_seq_12x12.
// Latency expectations follow APPMULT_SKIP_ZERO_EN when defined.
module tb_appmult_seq_12x12;

   typedef struct {
      logic [23:0] prod;
      logic [3:0]  tag;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] in_a = '0;
   logic [11:0] in_b = '0;
   logic [3:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [23:0] out_prod;
   logic [3:0]  out_tag;
   logic        busy;

   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   appmult_seq_12x12 #(.TAG_W(4), .ACC_W(24)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_prod  (out_prod),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   task automatic check(string t, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", t, got, exp);
      end
   endtask

   // Exact product minus the bits of the four lowest columns.
   function automatic int m66(int x, int y);
      int r;
      r = x * y;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4 - i; j++)
            if (((x >> i) & 1) == 1 && ((y >> j) & 1) == 1)
               r = r - (1 << (i + j));
      return r;
   endfunction

   function automatic int m1212(int a, int b);
      int al, ah, bl, bh;
      al = a % 64;
      ah = a / 64;
      bl = b % 64;
      bh = b / 64;
      return m66(al, bl) + 64 * m66(al, bh)
           + 64 * m66(ah, bl) + 4096 * m66(ah, bh);
   endfunction

   function automatic int exp_lat(int a, int b);
`ifdef APPMULT_SKIP_ZERO_EN
      int n;
      n = 1;
      if (a % 64 != 0 && b % 64 != 0) n++;
      if (a % 64 != 0 && b / 64 != 0) n++;
      if (a / 64 != 0 && b % 64 != 0) n++;
      if (a / 64 != 0 && b / 64 != 0) n++;
      return n;
`else
      return 5 + 0 * (a + b);
`endif
   endfunction

   function automatic exp_t mk(int a, int b, int tag);
      exp_t e;
      e.prod = 24'(m1212(a, b));
      e.tag  = 4'(tag);
      e.lat  = exp_lat(a, b);
      return e;
   endfunction

   // Returns at accept edge + #1.
   task automatic issue(int a, int b, int tag);
      int w;
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = 12'(a);
      in_b     = 12'(b);
      in_tag   = 4'(tag);
      w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("accept_timeout", 32'(in_ready), 1);
      sb.push_back(mk(a, b, tag));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Called at accept edge + #1; returns after the output handshake.
   task automatic collect(int hold);
      int   lat;
      exp_t e;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("out_valid_timeout", 32'(out_valid), 1);
      if (!out_valid) return;
      if (sb.size() == 0) begin
         check("sb_empty", 0, 1);
         return;
      end
      e = sb.pop_front();
      check("latency", 32'(lat), 32'(e.lat));
      check("out_prod", 32'(out_prod), 32'(e.prod));
      check("out_tag", 32'(out_tag), 32'(e.tag));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check("hold_valid", 32'(out_valid), 1);
         check("hold_prod", 32'(out_prod), 32'(e.prod));
         check("hold_tag", 32'(out_tag), 32'(e.tag));
         check("hold_in_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("post_hs_valid", 32'(out_valid), 0);
      check("post_hs_in_ready", 32'(in_ready), 1);
      check("post_hs_busy", 32'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ra, rb;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_out_prod", 32'(out_prod), 0);
      check("rst_out_tag", 32'(out_tag), 0);
      @(negedge clk);
      rst_n = 1'b1;

      check("const_63", 32'(m1212(63, 63)), 3920);
      check("const_4095", 32'(m1212(4095, 4095)), 16562000);

      issue(1, 1, 3);
      collect(0);
      issue(32, 32, 1);
      collect(0);
      issue(63, 63, 2);
      collect(0);
      issue(4095, 4095, 4);
      collect(0);
      issue(0, 4095, 7);
      collect(0);
      issue(64, 1, 8);
      collect(0);
      for (int k = 0; k < 6; k++) begin
         ra = int'($urandom_range(0, 4095));
         rb = int'($urandom_range(0, 4095));
         if (k == 2) ra = ra & 12'hFC0;
         if (k == 4) rb = rb & 12'h03F;
         issue(ra, rb, k + 9);
         collect(0);
      end

      // Back-to-back with a stalled sink; second request held pending.
      out_ready = 1'b0;
      issue(2047, 1234, 10);
      in_valid = 1'b1;
      in_a     = 12'd3000;
      in_b     = 12'd77;
      in_tag   = 4'd11;
      collect(10);
      sb.push_back(mk(3000, 77, 11));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("b2b_busy", 32'(busy), 1);
      check("b2b_in_ready", 32'(in_ready), 0);
      collect(0);

      // Abort mid-MUL, then verify a clean restart.
      issue(4095, 4095, 5);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(out_valid), 0);
      check("abort_in_ready", 32'(in_ready), 1);
      check("abort_busy", 32'(busy), 0);
      check("abort_out_prod", 32'(out_prod), 0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(63, 63, 6);
      collect(0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
